// File: rtl/escale_pkg.sv
// Shared types, widths and per-mode beat tables for the E-scale tail/rank loader.
package escale_pkg;

  localparam int unsigned WordW = 512;
  localparam int unsigned RegW  = 8;

  typedef enum logic [1:0] {StIdle, StTail, StRank, StDone} state_e;

  typedef enum logic {ModeSingle = 1'b0, ModeDual = 1'b1} mode_e;

  typedef struct packed {
    logic [RegW-1:0] start;
    logic [RegW-1:0] size;
    logic            last;
  } beat_t;

  // Indexed by mode: beats per tile and register span written per beat.
  localparam logic [2:0]      TailBeats [2] = '{3'd2, 3'd4};
  localparam logic [RegW-1:0] TailSize  [2] = '{8'd32, 8'd16};
  localparam logic [2:0]      RankBeats [2] = '{3'd1, 3'd2};
  localparam logic [RegW-1:0] RankSize  [2] = '{8'd64, 8'd32};

  // Register-file window for beat idx of the tail (rank=0) or rank (rank=1) phase.
  function automatic beat_t beat_lookup(mode_e mode, logic rank, logic [1:0] idx);
    beat_t      b;
    logic [2:0] beats;
    beats   = rank ? RankBeats[mode] : TailBeats[mode];
    b.size  = rank ? RankSize[mode] : TailSize[mode];
    b.start = 8'd1 + RegW'(idx) * b.size;
    b.last  = ({1'b0, idx} == (beats - 3'd1));
    return b;
  endfunction

endpackage

// File: rtl/escale_loader_if.sv
// Control, upstream beat and register-file write signals of the E-scale loader.
// ESCALE_LOADER_ERR_EN adds the sticky err flag.
interface escale_loader_if;
  import escale_pkg::*;

  logic             start;
  logic             mode;
  logic             in_valid;
  logic [WordW-1:0] in_word;
  logic             in_ready;
  logic             tail_set;
  logic [WordW-1:0] tail_word;
  logic [RegW-1:0]  tail_reg_start;
  logic [RegW-1:0]  tail_reg_size;
  logic             rank_set;
  logic [WordW-1:0] rank_word;
  logic [RegW-1:0]  rank_reg_start;
  logic [RegW-1:0]  rank_reg_size;
  logic             busy;
  logic             done;

`ifdef ESCALE_LOADER_ERR_EN
  logic             err;

  modport master (
    output start, mode, in_valid, in_word,
    input  in_ready, tail_set, tail_word, tail_reg_start, tail_reg_size,
    input  rank_set, rank_word, rank_reg_start, rank_reg_size, busy, done, err
  );

  modport slave (
    input  start, mode, in_valid, in_word,
    output in_ready, tail_set, tail_word, tail_reg_start, tail_reg_size,
    output rank_set, rank_word, rank_reg_start, rank_reg_size, busy, done, err
  );
`else
  modport master (
    output start, mode, in_valid, in_word,
    input  in_ready, tail_set, tail_word, tail_reg_start, tail_reg_size,
    input  rank_set, rank_word, rank_reg_start, rank_reg_size, busy, done
  );

  modport slave (
    input  start, mode, in_valid, in_word,
    output in_ready, tail_set, tail_word, tail_reg_start, tail_reg_size,
    output rank_set, rank_word, rank_reg_start, rank_reg_size, busy, done
  );
`endif

endinterface

// File: rtl/escale_loader.sv
// Loads one tile's E-scale tail beats then rank beats into their register files.
// ESCALE_LOADER_ERR_EN adds a sticky err flag for start requests made while busy.
module escale_loader
  import escale_pkg::*;
(
  input logic            clk,
  input logic            reset,
  escale_loader_if.slave bus
);

  state_e           state_q;
  mode_e            mode_q;
  logic [1:0]       cnt_q;
  logic             tail_set_q, rank_set_q, done_q;
  logic [WordW-1:0] tail_word_q, rank_word_q;
  logic [RegW-1:0]  tail_start_q, tail_size_q, rank_start_q, rank_size_q;

  logic  in_ready;
  logic  accept;
  beat_t beat;

  assign in_ready = (state_q == StTail) || (state_q == StRank);
  assign accept   = bus.in_valid & in_ready;
  assign beat     = beat_lookup(mode_q, state_q == StRank, cnt_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      mode_q       <= ModeSingle;
      cnt_q        <= '0;
      tail_set_q   <= 1'b0;
      rank_set_q   <= 1'b0;
      done_q       <= 1'b0;
      tail_word_q  <= '0;
      rank_word_q  <= '0;
      tail_start_q <= '0;
      tail_size_q  <= '0;
      rank_start_q <= '0;
      rank_size_q  <= '0;
    end else begin
      tail_set_q <= 1'b0;
      rank_set_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        StIdle: begin
          if (bus.start) begin
            state_q <= StTail;
            mode_q  <= mode_e'(bus.mode);
            cnt_q   <= '0;
          end
        end
        StTail: begin
          if (accept) begin
            tail_set_q   <= 1'b1;
            tail_word_q  <= bus.in_word;
            tail_start_q <= beat.start;
            tail_size_q  <= beat.size;
            cnt_q        <= beat.last ? 2'd0 : cnt_q + 2'd1;
            if (beat.last) state_q <= StRank;
          end
        end
        StRank: begin
          if (accept) begin
            rank_set_q   <= 1'b1;
            rank_word_q  <= bus.in_word;
            rank_start_q <= beat.start;
            rank_size_q  <= beat.size;
            cnt_q        <= beat.last ? 2'd0 : cnt_q + 2'd1;
            // done lines up with the final rank_set pulse.
            if (beat.last) begin
              state_q <= StDone;
              done_q  <= 1'b1;
            end
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

`ifdef ESCALE_LOADER_ERR_EN
  logic err_q;

  // A start while busy sets the flag; a start honoured in IDLE clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (bus.start) begin
      err_q <= (state_q != StIdle);
    end
  end

  assign bus.err = err_q;
`endif

  assign bus.in_ready       = in_ready;
  assign bus.busy           = (state_q != StIdle);
  assign bus.done           = done_q;
  assign bus.tail_set       = tail_set_q;
  assign bus.tail_word      = tail_word_q;
  assign bus.tail_reg_start = tail_start_q;
  assign bus.tail_reg_size  = tail_size_q;
  assign bus.rank_set       = rank_set_q;
  assign bus.rank_word      = rank_word_q;
  assign bus.rank_reg_start = rank_start_q;
  assign bus.rank_reg_size  = rank_size_q;

endmodule

// File: doc/escale_loader.md
ESCALE_LOADER -- requirements
Module: escale_loader

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  one-cycle request to load one tile's E-scale tail and rank data; honoured only in IDLE.
REQ-004 SHALL have port mode  input  1  0 = one 16b tail / 8b rank per reg, 1 = two per reg; sampled with start.
REQ-005 SHALL have port in_valid  input  1  upstream beat valid.
REQ-006 SHALL have port in_word  input  512  upstream beat payload.
REQ-007 SHALL have port in_ready  output  1  loader accepts a beat this cycle.
REQ-008 SHALL have ports tail_set output 1, tail_word output 512, tail_reg_start output 8, tail_reg_size output 8  tail register-file write.
REQ-009 SHALL have ports rank_set output 1, rank_word output 512, rank_reg_start output 8, rank_reg_size output 8  rank register-file write.
REQ-010 SHALL have ports busy output 1 (state != IDLE) and done output 1 (one-cycle completion pulse).

Function
REQ-011 SHALL implement FSM IDLE -> TAIL -> RANK -> DONE -> IDLE.
REQ-012 SHALL leave IDLE for TAIL on start=1 and latch mode into mode_q; word counter cleared.
REQ-013 SHALL drive in_ready=1 only in TAIL and RANK; beat accepted when in_valid & in_ready.
REQ-014 SHALL expect mode_q=0: 2 tail beats (start 1, 33; size 32), then 1 rank beat (start 1; size 64).
REQ-015 SHALL expect mode_q=1: 4 tail beats (start 1, 17, 33, 49; size 16), then 2 rank beats (start 1, 33; size 32).
REQ-016 SHALL, on a beat accepted in cycle N, register in_word plus start/size into the matching output group and assert that group's set for exactly cycle N+1 (latency 1); in_word is not modified.
REQ-017 SHALL hold word/start/size outputs stable when set is low; the other group's set stays 0.
REQ-018 SHALL advance TAIL -> RANK on acceptance of the last tail beat, and RANK -> DONE on acceptance of the last rank beat, clearing the counter at each transition.
REQ-019 SHALL assert done in DONE for one cycle, coincident with the final rank_set, then return to IDLE.
REQ-020 SHALL stall indefinitely with in_valid=0 while holding state, counter and outputs; set stays 0 during stalls.
REQ-021 SHALL ignore start while busy=1, including in DONE; start and the next accepted beat may not share a cycle.
REQ-022 SHALL accept back-to-back beats every cycle, producing consecutive set pulses.

Reset
REQ-023 SHALL on reset return to IDLE, clear counter and mode_q, and drive in_ready, tail_set, rank_set, busy, done to 0 and all word/start/size outputs to 0 in the next cycle.
REQ-024 SHALL on reset mid-transfer abandon the tile: no further set pulses and no done.

Configuration
REQ-025 SHALL, with ESCALE_LOADER_ERR_EN defined, add output err (1 bit): sticky-set the cycle after start=1 while busy=1, cleared by reset or by a start honoured in IDLE.
REQ-026 SHALL, without ESCALE_LOADER_ERR_EN, omit the err port and silently drop start while busy.

Structure
REQ-027 SHALL place word width (512), reg-field width (8), FSM state enum, mode encodings and per-mode beat-count/start/size tables in shared package escale_pkg.
REQ-028 SHALL be a single module; no sub-module, with the start/size lookup as a package function.

Verification
REQ-029 SHALL cover mode 0 with a continuous stream: start, beats A,B,C each cycle -> tail_set with start 1/size 32 word A, then 33/32 word B, then rank_set 1/64 word C plus done on the same cycle; busy falls the next cycle.
REQ-030 SHALL cover mode 1 with in_valid toggled 1,0,1,0 -> six set pulses only after accepted beats, tail starts 1,17,33,49 size 16, rank starts 1,33 size 32, done with the 2nd rank_set.
REQ-031 SHALL cover start during TAIL in mode 1 -> ignored, the beat sequence unchanged; with ESCALE_LOADER_ERR_EN, err=1 from the next cycle until the next honoured start.
REQ-032 SHALL cover reset asserted after 1 tail beat -> all outputs 0 the next cycle, no done; a new start then runs a full sequence from tail start 1.
REQ-033 SHALL cover in_valid=1 while IDLE for 5 cycles -> in_ready=0, no set pulses, outputs unchanged.
REQ-034 SHALL cover back-to-back tiles: start in the cycle after done -> honoured, and the mode sampled then is used.
